vram_byte_port: RTL and testbench
=================================

Name: vram_byte_port

Overview:
CPU-facing byte access port that initiates 32-bit word cycles on the VRAM slave bus: 15-bit word address, 32-bit data, 4-bit byte select, write strobe, read data one cycle after the address edge. It holds a 17-bit byte address with a programmable auto-increment/decrement step. Each accepted write is applied as a byte-lane write. The byte at the current address is prefetched, so CPU reads return immediately from a register. It sits between the host register file and the VRAM arbiter. A bus request stays pending until the arbiter grants it.

Parameters:
ADDR_W, 17, byte address width; bus word address is ADDR_W-2 = 15 bits, wraps modulo 2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
addr_wr  in  1  strobe: load byte address
addr_wrdata  in  17  new byte address
incr_wr  in  1  strobe: load step control
incr_wrdata  in  5  [3:0] step index, [4] 1 = decrement
data_wr  in  1  strobe: write byte at current address
data_wrdata  in  8  byte to write
data_rd  in  1  strobe: CPU consumed data_rddata; advance and refetch
data_rddata  out  8  prefetched byte at current address
addr_q  out  17  current byte address
busy  out  1  bus operation in progress
overrun  out  1  sticky: a strobe arrived while busy
bus_req  out  1  request bus cycle
bus_ack  in  1  grant; the RAM samples the address/data on the edge ending this cycle
bus_addr  out  15  word address = addr_q[16:2]
bus_wrdata  out  32  data_wrdata replicated on all 4 lanes
bus_wrbytesel  out  4  one-hot 1<<addr_q[1:0] for writes, 0 for reads
bus_write  out  1  1 in WR_REQ only
bus_rddata  in  32  RAM read data, valid the cycle after the ack

Behaviour:
- Reset (async) values:
  - State: IDLE. addr_q = 0, step = index 0 (increment), data_rddata = 0.
  - bus_req = 0, bus_write = 0, bus_wrbytesel = 0, bus_wrdata = 0, overrun = 0, busy = 0.
  - No automatic prefetch after reset.
- Step table, index 0..15: 0,1,2,4,8,16,32,64,128,256,512,40,80,160,320,640.
  - advance: addr_q <= addr_q ± step, modulo 2^17 (wraps both directions).
- States:
  - IDLE -> WR_REQ: on data_wr. Latch data_wrdata.
  - IDLE -> RD_REQ: on data_rd (advance first), or on addr_wr (load addr_q).
  - incr_wr in IDLE loads the step control; state stays IDLE.
  - WR_REQ: bus_req = 1, bus_write = 1. On bus_ack: advance addr_q, go to RD_REQ (refetch at the new address).
  - RD_REQ: bus_req = 1, bus_write = 0, bus_wrbytesel = 0. On bus_ack: go to RD_WAIT and register lane = addr_q[1:0].
  - RD_WAIT: data_rddata <= bus_rddata[8*lane +: 8], little-endian lanes. Go to IDLE.
- All bus outputs are registered and stay stable while bus_req = 1 until the ack cycle.
- busy = (state != IDLE), registered.
- Strobe priority in IDLE when several arrive together: addr_wr > data_wr > data_rd. incr_wr is always applied alongside.
- Any strobe while busy, including one in the same cycle a lower-priority strobe is dropped: the strobe is ignored and overrun <= 1. addr_wr accepted in IDLE clears overrun.
- Latency with immediate ack:
  - data_rd / addr_wr: busy for 2 cycles; new data_rddata visible 2 cycles after the strobe edge.
  - data_wr: busy for 3 cycles.
- A delayed ack extends RD_REQ/WR_REQ indefinitely; nothing else changes.
- Reset mid-operation: bus_req drops immediately. Any in-flight read is discarded. A write acked on the same edge as reset assertion is undefined; the arbiter gates that case.

Decomposition:
- Package vram_pkg:
  - state enum {IDLE, WR_REQ, RD_REQ, RD_WAIT}.
  - STEP_TABLE constant (16 x 10-bit).
  - ADDR_W / WORD_AW localparams.
- Sub-module vram_addr_step: combinational next-address unit (addr, index, decr -> addr_next) with modulo wrap. It is reused by the second data port.

Test Plan:
- Load RAM word 1 = 0xDDCCBBAA, addr_wr 0x00005, incr index 1 -> one read cycle with bus_addr 0x0001 and bytesel 0000; data_rddata = 0xBB; busy high for 2 cycles.
- At addr 0x00006 with incr index 1, data_wr 0x5A -> bus_addr 0x0001, bytesel 0100, wrdata 0x5A5A5A5A, bus_write 1. Then refetch: addr_q = 0x00007, data_rddata = 0xDD, word 1 = 0xDD5ABBAA.
- addr 0x00000, incr_wrdata 5'b1_0010 (decrement by 2), data_rd -> addr_q = 0x1FFFE, bus_addr 0x7FFF, lane 2 returned.
- Hold bus_ack low for 5 cycles during RD_REQ -> bus_req, bus_addr and bytesel stable, busy = 1; completion 1 cycle after ack.
- data_wr while busy -> no extra bus write, overrun = 1; subsequent addr_wr in IDLE -> overrun = 0.
- Assert rst during RD_WAIT -> bus_req = 0 and busy = 0 immediately; data_rddata = 0, addr_q = 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM byte access ports.
package vram_pkg;

    localparam int ADDR_W  = 17;
    localparam int WORD_AW = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    // Entry 0 sits in the lowest slice so STEP_TABLE[idx] reads naturally.
    localparam logic [15:0][9:0] STEP_TABLE = {
        10'd640, 10'd320, 10'd160, 10'd80,
        10'd40,  10'd512, 10'd256, 10'd128,
        10'd64,  10'd32,  10'd16,  10'd8,
        10'd4,   10'd2,   10'd1,   10'd0
    };

endpackage

// File: rtl/vram_addr_step.sv
// Combinational next-address unit: addr +/- table step, wrapping modulo 2^ADDR_W.
module vram_addr_step
    import vram_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic [AW-1:0] addr,
    input  logic [3:0]    index,
    input  logic          decr,
    output logic [AW-1:0] addr_next
);

    logic [AW-1:0] step_s;

    assign step_s = {{(AW-10){1'b0}}, STEP_TABLE[index]};

    // Add or subtract the step; overflow past either end simply wraps.
    always_comb begin
        addr_next = addr;
        if (decr) begin
            addr_next = addr - step_s;
        end else begin
            addr_next = addr + step_s;
        end
    end

endmodule

// File: rtl/vram_byte_port.sv
// CPU byte port onto the 32-bit VRAM bus: byte-lane writes, prefetched reads,
// and a stepping byte address.
module vram_byte_port
    import vram_pkg::*;
#(
    parameter int ADDR_W = vram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_wr,
    input  logic [ADDR_W-1:0] addr_wrdata,
    input  logic              incr_wr,
    input  logic [4:0]        incr_wrdata,
    input  logic              data_wr,
    input  logic [7:0]        data_wrdata,
    input  logic              data_rd,
    output logic [7:0]        data_rddata,
    output logic [ADDR_W-1:0] addr_q,
    output logic              busy,
    output logic              overrun,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_wrdata,
    output logic [3:0]        bus_wrbytesel,
    output logic              bus_write,
    input  logic [31:0]       bus_rddata
);

    state_t            state_r;
    logic [3:0]        step_idx_r;
    logic              step_dec_r;
    logic [1:0]        lane_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              any_strobe_s;
    logic              dropped_s;

    vram_addr_step #(.AW(ADDR_W)) u_step (
        .addr      (addr_q),
        .index     (step_idx_r),
        .decr      (step_dec_r),
        .addr_next (addr_next_s)
    );

    assign bus_addr     = addr_q[ADDR_W-1:2];
    assign any_strobe_s = addr_wr | incr_wr | data_wr | data_rd;
    // A lower-priority strobe losing arbitration in IDLE counts as an overrun.
    assign dropped_s    = (addr_wr & (data_wr | data_rd)) | (data_wr & data_rd);

    // Port sequencer: strobe arbitration, bus handshake and prefetch capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            addr_q        <= '0;
            step_idx_r    <= 4'd0;
            step_dec_r    <= 1'b0;
            lane_r        <= 2'd0;
            data_rddata   <= 8'h00;
            bus_req       <= 1'b0;
            bus_write     <= 1'b0;
            bus_wrbytesel <= 4'b0000;
            bus_wrdata    <= 32'h0000_0000;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (incr_wr) begin
                        step_dec_r <= incr_wrdata[4];
                        step_idx_r <= incr_wrdata[3:0];
                    end
                    if (dropped_s) begin
                        overrun <= 1'b1;
                    end else if (addr_wr) begin
                        overrun <= 1'b0;
                    end
                    if (addr_wr) begin
                        addr_q  <= addr_wrdata;
                        bus_req <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= RD_REQ;
                    end else if (data_wr) begin
                        bus_wrdata    <= {4{data_wrdata}};
                        bus_wrbytesel <= 4'b0001 << addr_q[1:0];
                        bus_write     <= 1'b1;
                        bus_req       <= 1'b1;
                        busy          <= 1'b1;
                        state_r       <= WR_REQ;
                    end else if (data_rd) begin
                        addr_q  <= addr_next_s;
                        bus_req <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (any_strobe_s) begin
                        overrun <= 1'b1;
                    end
                    if (bus_ack) begin
                        addr_q        <= addr_next_s;
                        bus_write     <= 1'b0;
                        bus_wrbytesel <= 4'b0000;
                        state_r       <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (any_strobe_s) begin
                        overrun <= 1'b1;
                    end
                    if (bus_ack) begin
                        lane_r  <= addr_q[1:0];
                        bus_req <= 1'b0;
                        state_r <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (any_strobe_s) begin
                        overrun <= 1'b1;
                    end
                    data_rddata <= bus_rddata[{lane_r, 3'b000} +: 8];
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    bus_req       <= 1'b0;
                    bus_write     <= 1'b0;
                    bus_wrbytesel <= 4'b0000;
                    busy          <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_byte_port.sv
// Directed bench for vram_byte_port with a small behavioural VRAM on the bus.
module tb_vram_byte_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_wr;
    logic [16:0] addr_wrdata;
    logic        incr_wr;
    logic [4:0]  incr_wrdata;
    logic        data_wr;
    logic [7:0]  data_wrdata;
    logic        data_rd;
    logic [7:0]  data_rddata;
    logic [16:0] addr_q;
    logic        busy;
    logic        overrun;
    logic        bus_req;
    logic        bus_ack;
    logic [14:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_wrbytesel;
    logic        bus_write;
    logic [31:0] bus_rddata;

    logic        ack_en;
    logic [31:0] mem [32768];
    int          wr_count;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    assign bus_ack = bus_req & ack_en;

    vram_byte_port dut (
        .clk           (clk),
        .rst           (rst),
        .addr_wr       (addr_wr),
        .addr_wrdata   (addr_wrdata),
        .incr_wr       (incr_wr),
        .incr_wrdata   (incr_wrdata),
        .data_wr       (data_wr),
        .data_wrdata   (data_wrdata),
        .data_rd       (data_rd),
        .data_rddata   (data_rddata),
        .addr_q        (addr_q),
        .busy          (busy),
        .overrun       (overrun),
        .bus_req       (bus_req),
        .bus_ack       (bus_ack),
        .bus_addr      (bus_addr),
        .bus_wrdata    (bus_wrdata),
        .bus_wrbytesel (bus_wrbytesel),
        .bus_write     (bus_write),
        .bus_rddata    (bus_rddata)
    );

    // VRAM model: contents preloaded under reset, byte-lane writes, read data one cycle after ack.
    always @(posedge clk) begin
        if (rst) begin
            mem[1]        <= 32'hDDCC_BBAA;
            mem[2]        <= 32'h8765_4321;
            mem[15'h7FFF] <= 32'h4433_2211;
            wr_count      <= 0;
        end else if (bus_req && bus_ack) begin
            if (bus_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_wrbytesel[i]) mem[bus_addr][8*i +: 8] <= bus_wrdata[8*i +: 8];
                end
                wr_count <= wr_count + 1;
            end else begin
                bus_rddata <= mem[bus_addr];
            end
        end
    end

    task automatic strobe_addr(input logic [16:0] a, input logic do_incr, input logic [4:0] inc);
        addr_wr = 1'b1; addr_wrdata = a; incr_wr = do_incr; incr_wrdata = inc;
        @(posedge clk); #1;
        addr_wr = 1'b0; incr_wr = 1'b0;
    endtask

    task automatic strobe_data_wr(input logic [7:0] d);
        data_wr = 1'b1; data_wrdata = d;
        @(posedge clk); #1;
        data_wr = 1'b0;
    endtask

    task automatic strobe_data_rd();
        data_rd = 1'b1;
        @(posedge clk); #1;
        data_rd = 1'b0;
    endtask

    // Called just after the strobe edge; returns the number of sampled busy cycles.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        total++; if (addr_q !== 17'h00000) begin bad++; $display("FAIL reset_addr_q got=%h exp=00000", addr_q); end
        total++; if (data_rddata !== 8'h00) begin bad++; $display("FAIL reset_rddata got=%h exp=00", data_rddata); end
        total++; if ({busy, overrun, bus_req, bus_write} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, overrun, bus_req, bus_write}); end
        total++; if ({bus_wrbytesel, bus_wrdata} !== 36'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {bus_wrbytesel, bus_wrdata}); end
    endtask

    task automatic test_read();
        int n;
        strobe_addr(17'h00005, 1'b1, 5'b0_0001);
        total++; if ({bus_req, bus_write, bus_wrbytesel} !== 6'b10_0000) begin bad++; $display("FAIL rd_bus_ctl got=%b exp=100000", {bus_req, bus_write, bus_wrbytesel}); end
        total++; if (bus_addr !== 15'h0001) begin bad++; $display("FAIL rd_bus_addr got=%h exp=0001", bus_addr); end
        wait_idle(n);
        total++; if (n !== 2) begin bad++; $display("FAIL rd_busy_cycles got=%0d exp=2", n); end
        total++; if (data_rddata !== 8'hBB) begin bad++; $display("FAIL rd_data got=%h exp=BB", data_rddata); end
        strobe_data_rd();
        total++; if (addr_q !== 17'h00006) begin bad++; $display("FAIL rd_incr_addr got=%h exp=00006", addr_q); end
        wait_idle(n);
        total++; if (data_rddata !== 8'hCC) begin bad++; $display("FAIL rd_incr_data got=%h exp=CC", data_rddata); end
    endtask

    task automatic test_write();
        int n;
        strobe_data_wr(8'h5A);
        total++; if ({bus_req, bus_write, bus_wrbytesel} !== 6'b11_0100) begin bad++; $display("FAIL wr_bus_ctl got=%b exp=110100", {bus_req, bus_write, bus_wrbytesel}); end
        total++; if (bus_wrdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL wr_wrdata got=%h exp=5a5a5a5a", bus_wrdata); end
        total++; if (bus_addr !== 15'h0001) begin bad++; $display("FAIL wr_bus_addr got=%h exp=0001", bus_addr); end
        wait_idle(n);
        total++; if (n !== 3) begin bad++; $display("FAIL wr_busy_cycles got=%0d exp=3", n); end
        total++; if (addr_q !== 17'h00007) begin bad++; $display("FAIL wr_addr_q got=%h exp=00007", addr_q); end
        total++; if (data_rddata !== 8'hDD) begin bad++; $display("FAIL wr_refetch got=%h exp=DD", data_rddata); end
        total++; if (mem[1] !== 32'hDD5A_BBAA) begin bad++; $display("FAIL wr_mem_word got=%h exp=dd5abbaa", mem[1]); end
    endtask

    task automatic test_decrement_wrap();
        int n;
        strobe_addr(17'h00000, 1'b1, 5'b1_0010);
        wait_idle(n);
        strobe_data_rd();
        total++; if (addr_q !== 17'h1FFFE) begin bad++; $display("FAIL dec_addr_q got=%h exp=1fffe", addr_q); end
        total++; if (bus_addr !== 15'h7FFF) begin bad++; $display("FAIL dec_bus_addr got=%h exp=7fff", bus_addr); end
        wait_idle(n);
        total++; if (data_rddata !== 8'h33) begin bad++; $display("FAIL dec_lane2 got=%h exp=33", data_rddata); end
    endtask

    task automatic test_delayed_ack();
        ack_en = 1'b0;
        strobe_addr(17'h00009, 1'b1, 5'b0_0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus_req, busy, bus_wrbytesel, bus_addr} !== {1'b1, 1'b1, 4'b0000, 15'h0002}) begin
                bad++;
                $display("FAIL stall_stable cycle=%0d got req=%b busy=%b sel=%b addr=%h exp req=1 busy=1 sel=0000 addr=0002",
                         i, bus_req, busy, bus_wrbytesel, bus_addr);
            end
        end
        ack_en = 1'b1;
        @(posedge clk); #1;
        total++; if ({bus_req, busy} !== 2'b01) begin bad++; $display("FAIL stall_after_ack got=%b exp=01", {bus_req, busy}); end
        @(posedge clk); #1;
        total++; if ({busy, data_rddata} !== {1'b0, 8'h43}) begin bad++; $display("FAIL stall_done got busy=%b data=%h exp busy=0 data=43", busy, data_rddata); end
    endtask

    task automatic test_overrun();
        int n;
        int wr_before;
        wr_before = wr_count;
        strobe_addr(17'h00004, 1'b0, 5'b0_0000);
        strobe_data_wr(8'h77);
        wait_idle(n);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        total++; if (wr_count !== wr_before) begin bad++; $display("FAIL ovr_no_write got=%0d exp=%0d", wr_count, wr_before); end
        total++; if (data_rddata !== 8'hAA) begin bad++; $display("FAIL ovr_rddata got=%h exp=AA", data_rddata); end
        strobe_addr(17'h00004, 1'b0, 5'b0_0000);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        wait_idle(n);
    endtask

    task automatic test_reset_mid_read();
        strobe_addr(17'h00005, 1'b0, 5'b0_0000);
        @(posedge clk); #1;
        total++; if ({bus_req, busy} !== 2'b01) begin bad++; $display("FAIL mid_in_rd_wait got=%b exp=01", {bus_req, busy}); end
        rst = 1'b1;
        #1;
        total++; if ({bus_req, busy} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags got=%b exp=00", {bus_req, busy}); end
        total++; if ({addr_q, data_rddata} !== 25'h0) begin bad++; $display("FAIL mid_rst_regs got addr=%h data=%h exp 0", addr_q, data_rddata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if ({busy, data_rddata} !== 9'h0) begin bad++; $display("FAIL mid_discard got busy=%b data=%h exp 0", busy, data_rddata); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; ack_en = 1'b1;
        addr_wr = 1'b0; addr_wrdata = 17'h0; incr_wr = 1'b0; incr_wrdata = 5'h0;
        data_wr = 1'b0; data_wrdata = 8'h0; data_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_read();
        test_write();
        test_decrement_wrap();
        test_delayed_ack();
        test_overrun();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
